// File: rtl/video_timing_gen_pkg.sv
// rtl/video_timing_gen_pkg.sv - 800x600@60 timing constants and shared types for video_timing_gen
package video_timing_pkg;

  localparam int CNT_W = 11;
  localparam int PIX_W = 10;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;

  // Total period of one axis: active area plus the three blanking segments
  function automatic int span_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = span_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = span_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // One registered raster sample; every field is loaded on the same edge
  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             de;
    logic             frame_start;
    logic [PIX_W-1:0] pixels_x;
    logic [PIX_W-1:0] pixels_y;
  } vid_out_t;

endpackage

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - raster output bundle; frameCount present with VTG_FRAME_COUNT_EN
interface video_timing_gen_if;
  logic       hs;
  logic       vs;
  logic       de;
  logic [9:0] pixelsX;
  logic [9:0] pixelsY;
  logic       frameStart;
`ifdef VTG_FRAME_COUNT_EN
  logic [7:0] frameCount;

  modport master (output hs, vs, de, pixelsX, pixelsY, frameStart, frameCount);
  modport slave  (input  hs, vs, de, pixelsX, pixelsY, frameStart, frameCount);
`else
  modport master (output hs, vs, de, pixelsX, pixelsY, frameStart);
  modport slave  (input  hs, vs, de, pixelsX, pixelsY, frameStart);
`endif
endinterface

// File: rtl/video_timing_gen_mod_counter.sv
// rtl/video_timing_gen_mod_counter.sv - modulo-N counter with clock enable, wrap flag and reset-load value
module mod_counter #(
  parameter int N    = 1056,
  parameter int W    = 11,
  parameter int LOAD = N - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_next,
  output logic         wrap
);

  localparam logic [W-1:0] LAST     = W'(N - 1);
  localparam logic [W-1:0] LOAD_VAL = W'(LOAD);

  // Terminal count: the next step returns to zero
  assign wrap = (cnt == LAST);

  // Look-ahead value so the owner can decode outputs for the upcoming edge
  always_comb begin
    cnt_next = cnt;
    if (inc) begin
      cnt_next = wrap ? '0 : cnt + W'(1);
    end
  end

  // Count register; frozen whenever ce is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD_VAL;
    end else if (ce) begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - free-running raster timing generator; VTG_FRAME_COUNT_EN adds frameCount
import video_timing_pkg::*;

module video_timing_gen #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic               pixelClk,
  input  logic               resetN,
  input  logic               ce,
  video_timing_gen_if.master vid
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt, h_next;
  logic [CNT_W-1:0] v_cnt, v_next;
  logic             h_wrap, v_wrap;

  vid_out_t nxt;
  vid_out_t cur;

  // Both counters reset to their last value so the first enabled edge lands on (0,0)
  mod_counter #(.N(H_TOTAL), .W(CNT_W), .LOAD(H_TOTAL - 1)) u_h_cnt (
    .clk      (pixelClk),
    .rst_n    (resetN),
    .ce       (ce),
    .inc      (1'b1),
    .cnt      (h_cnt),
    .cnt_next (h_next),
    .wrap     (h_wrap)
  );

  mod_counter #(.N(V_TOTAL), .W(CNT_W), .LOAD(V_TOTAL - 1)) u_v_cnt (
    .clk      (pixelClk),
    .rst_n    (resetN),
    .ce       (ce),
    .inc      (h_wrap),
    .cnt      (v_cnt),
    .cnt_next (v_next),
    .wrap     (v_wrap)
  );

  // Decode the upcoming counter pair so outputs line up with the counter advance
  always_comb begin
    nxt             = '0;
    nxt.de          = (h_next < H_ACT) && (v_next < V_ACT);
    nxt.hs          = ((h_next >= HS_BEG) && (h_next < HS_END)) ? HS_POL : ~HS_POL;
    nxt.vs          = ((v_next >= VS_BEG) && (v_next < VS_END)) ? VS_POL : ~VS_POL;
    // Both counters at terminal count means the next pixel is (0,0)
    nxt.frame_start = h_wrap && v_wrap;
    if (nxt.de) begin
      nxt.pixels_x = h_next[PIX_W-1:0];
      nxt.pixels_y = v_next[PIX_W-1:0];
    end
  end

  // Output register; an aborted frame drops straight to idle levels
  always_ff @(posedge pixelClk or negedge resetN) begin
    if (!resetN) begin
      cur.hs          <= ~HS_POL;
      cur.vs          <= ~VS_POL;
      cur.de          <= 1'b0;
      cur.frame_start <= 1'b0;
      cur.pixels_x    <= '0;
      cur.pixels_y    <= '0;
    end else if (ce) begin
      cur <= nxt;
    end
  end

  assign vid.hs         = cur.hs;
  assign vid.vs         = cur.vs;
  assign vid.de         = cur.de;
  assign vid.pixelsX    = cur.pixels_x;
  assign vid.pixelsY    = cur.pixels_y;
  assign vid.frameStart = cur.frame_start;

`ifdef VTG_FRAME_COUNT_EN
  logic [7:0] frame_count;

  // Advance on the same edge that raises frameStart, so the new count accompanies the pulse
  always_ff @(posedge pixelClk or negedge resetN) begin
    if (!resetN) begin
      frame_count <= 8'd0;
    end else if (ce && nxt.frame_start) begin
      frame_count <= frame_count + 8'd1;
    end
  end

  assign vid.frameCount = frame_count;
`endif

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Free-running VESA 800x600@60 Hz raster timing generator in the `pixelClk` domain (40 MHz). It produces `hs`, `vs`, `de` and the active-area coordinates `pixelsX`/`pixelsY`. These outputs feed the pattern generator and the DVI/VGA encoders directly downstream. All outputs are registered and mutually aligned, so consumers need no extra delay matching.

## Interface
- `H_ACTIVE`, 800, active pixels per line
- `H_FP`, 40, horizontal front porch (pixels)
- `H_SYNC`, 128, horizontal sync width (pixels)
- `H_BP`, 88, horizontal back porch (pixels)
- `V_ACTIVE`, 600, active lines per frame
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 4, vertical sync width (lines)
- `V_BP`, 23, vertical back porch (lines)
- `HS_POL`, 1, asserted level of `hs`
- `VS_POL`, 1, asserted level of `vs`
- `pixelClk`  in  1  pixel clock, rising-edge
- `resetN`  in  1  asynchronous, active-low reset
- `ce`  in  1  clock enable; when low, all state and outputs hold
- `hs`  out  1  horizontal sync, level `HS_POL` when asserted
- `vs`  out  1  vertical sync, level `VS_POL` when asserted
- `de`  out  1  high inside the active area
- `pixelsX`  out  10  active column; 0 when `de`=0
- `pixelsY`  out  10  active line; 0 when `de`=0
- `frameStart`  out  1  one-cycle pulse coincident with pixel (0,0)

## Operation
- Internal counters: `hCnt` wraps over 0..H_TOTAL-1 (H_TOTAL = sum of the four H params = 1056). `vCnt` wraps over 0..V_TOTAL-1 (628). Both are 11 bits wide.
- On each edge with `ce`=1:
  - `hCnt` increments.
  - At H_TOTAL-1, `hCnt` wraps to 0 and `vCnt` increments.
  - When both counters are at their maximum, both wrap to 0.
- On the same edge, outputs are loaded from the decode of the *next* counter values (h', v'):
  - `de` = (h' < H_ACTIVE) && (v' < V_ACTIVE)
  - `hs` asserted for h' in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - `vs` asserted for v' in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). `vs` therefore toggles only on edges where h' = 0.
  - `pixelsX`/`pixelsY` = h'/v' truncated to 10 bits when `de`=1, else 0.
  - `frameStart` = (h'==0 && v'==0).
- Reset:
  - `hCnt` = H_TOTAL-1 and `vCnt` = V_TOTAL-1, so the first enabled edge produces pixel (0,0) of a full frame.
  - `hs` = !HS_POL, `vs` = !VS_POL, `de` = 0, `pixelsX` = `pixelsY` = 0, `frameStart` = 0.
- Reset asserted mid-frame aborts the frame immediately. There is no partial-line completion.
- `ce`=0 for any number of cycles: the raster is frozen, and `frameStart` holds its current value (it is not re-pulsed).

## Timing
- Output latency: 1 `pixelClk` edge from counter advance. All outputs update on the same edge and are never skewed against each other.
- Line = 1056 cycles; frame = 663168 cycles = 16.58 ms at 40 MHz.
- `de` is high for 800 consecutive cycles per line, on 600 lines.
- `hs` is high (with `HS_POL`=1) for 128 cycles, starting 840 cycles after line start.
- `vs` is high for 4 lines = 4224 cycles, starting at line 601, h=0.
- `frameStart` fires once per 663168 enabled cycles.

## Configuration
- `VTG_FRAME_COUNT_EN`: when defined, adds output `frameCount` (out, 8 bits).
  - `frameCount` resets to 0 and increments (wrapping at 255) on every edge that asserts `frameStart`.
  - It is used by the pattern generator for animated patterns.
- When not defined, the port and its register are absent, and the remaining behaviour is identical.

## Structure
- Shared package `video_timing_pkg`:
  - 800x600@60 default timing constants.
  - H_TOTAL/V_TOTAL derivation.
  - Counter width constant (11).
- One sub-module, `mod_counter`: a parameterised modulo-N counter with `ce`, a wrap flag, and reset-load value. It is instantiated twice, for horizontal and vertical. Decode and output registers live in the top.

## Test plan
- Release reset, `ce`=1 → on the first edge: `de`=1, `pixelsX`=0, `pixelsY`=0, `frameStart`=1.
- Run 1056 cycles → `de` high for exactly 800 cycles; `hs` high for cycles 840..967; `pixelsX` goes 0..799, then 0 during blanking.
- Run a full frame → 600 `de` lines. `vs` asserts on the edge where v'=601, h'=0, and deasserts at v'=605, h'=0. `frameStart` recurs after 663168 cycles.
- Toggle `ce` low for 50 cycles at h'=400, v'=100 → all outputs frozen. On resume the next values are X=401, Y=100, with no skipped pixel.
- Assert `resetN` low at h'=500, v'=300 → all outputs take their reset values asynchronously. After release, the first edge gives (0,0) with `frameStart`=1.
- With `VTG_FRAME_COUNT_EN` defined, run 257 frames → `frameCount` reads 0 after reset, increments on each `frameStart`, and wraps 255→0.
